// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer RAM arbiter: buffered recorder writes vs. req/ack readout.
// Define FB_ARB_STATS_EN to add the saturating drop_count output.
module fb_port_arbiter #(
    parameter int unsigned WFIFO_DEPTH = 4,
    parameter int unsigned HIGH_WATER  = 3,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                                 pclock,
    input  logic                                 reset,
    input  logic                                 end_frame,
    input  logic                                 wr_we,
    input  logic [18:0]                          wr_addr,
    input  logic [63:0]                          wr_data,
    input  logic                                 rd_req,
    input  logic [18:0]                          rd_addr,
    output logic                                 rd_ack,
    output logic                                 rd_valid,
    output logic [63:0]                          rd_data,
    input  logic                                 mem_stall,
    output logic [18:0]                          mem_addr,
    output logic                                 mem_we,
    output logic [63:0]                          mem_wdata,
    input  logic [63:0]                          mem_rdata,
    output logic                                 overflow,
    output logic [$clog2(WFIFO_DEPTH+1)-1:0]     fifo_level
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]                          drop_count
`endif
);

    localparam int unsigned CW = $clog2(WFIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(WFIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(WFIFO_DEPTH);
    localparam logic [CW-1:0] HWM_C   = CW'(HIGH_WATER);

    localparam logic [0:0] GNT_WRITE = 1'b0;
    localparam logic [0:0] GNT_READ  = 1'b1;

    logic [18:0]          fifo_addr [WFIFO_DEPTH];
    logic [63:0]          fifo_data [WFIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [0:0]           last_grant;
    logic [MEM_LATENCY:0] tag;
    logic [MEM_LATENCY:0] tag_next;
    logic                 grant_wr;
    logic                 grant_rd;
    logic                 push;
    logic                 pop;
    logic                 drop;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!reset && !mem_stall) begin
            if (count != '0 &&
                (count >= HWM_C || !rd_req || last_grant == GNT_READ)) begin
                grant_wr = 1'b1;
            end else if (rd_req) begin
                grant_rd = 1'b1;
            end
        end
        pop  = grant_wr;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push = wr_we && (count < DEPTH_C || pop);
        drop = wr_we && !push;
        tag_next    = tag << 1;
        tag_next[0] = grant_rd;
    end

    assign rd_ack     = grant_rd;
    assign fifo_level = count;

    always_ff @(posedge pclock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge pclock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= GNT_READ;
            tag        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (grant_wr) begin
                last_grant <= GNT_WRITE;
            end else if (grant_rd) begin
                last_grant <= GNT_READ;
            end

            mem_we <= grant_wr;
            if (grant_wr) begin
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
            end else if (grant_rd) begin
                mem_addr <= rd_addr;
            end

            // Tag exits the same cycle mem_rdata for that read is valid.
            tag      <= tag_next;
            rd_valid <= tag[MEM_LATENCY];
            if (tag[MEM_LATENCY]) rd_data <= mem_rdata;

            if (drop) begin
                overflow <= 1'b1;
            end else if (end_frame) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge pclock) begin
        if (reset) begin
            drop_count <= '0;
        end else if (end_frame) begin
            drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a latency-1 RAM model and write/read scoreboards.
module tb_fb_port_arbiter;

    logic        pclock = 1'b0;
    logic        reset = 1'b1;
    logic        end_frame = 1'b0;
    logic        wr_we = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rd_req = 1'b0;
    logic [18:0] rd_addr = '0;
    logic        rd_ack;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        mem_stall = 1'b0;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        overflow;
    logic [2:0]  fifo_level;
`ifdef FB_ARB_STATS_EN
    logic [15:0] drop_count;
`endif

    fb_port_arbiter dut (
        .pclock     (pclock),
        .reset      (reset),
        .end_frame  (end_frame),
        .wr_we      (wr_we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mem_stall  (mem_stall),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .overflow   (overflow),
        .fifo_level (fifo_level)
`ifdef FB_ARB_STATS_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 pclock = ~pclock;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge pclock) cyc <= cyc + 1;

    function automatic logic [63:0] init_val(input logic [18:0] a);
        return {32'hFEED_BEEF, 13'd0, a};
    endfunction

    function automatic logic [63:0] wdata_of(input logic [18:0] a);
        return {16'hD00D, 29'd0, a};
    endfunction

    // Latency-1 RAM: mem_rdata is valid one cycle after mem_addr.
    logic [63:0] ram [0:1023];
    initial for (int i = 0; i < 1024; i++) ram[i] = init_val(19'(i));
    always @(posedge pclock) begin
        if (mem_we === 1'b1) ram[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[9:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [18:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } rd_exp_t;

    wr_exp_t wq[$];
    rd_exp_t rq[$];
    wr_exp_t we_e;
    rd_exp_t re_e;

    always @(negedge pclock) begin
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mem_we: got write to %0h, expected none", mem_addr);
            end else begin
                we_e = wq.pop_front();
                check("mem_addr", 64'(mem_addr), 64'(we_e.addr));
                check("mem_wdata", mem_wdata, we_e.data);
                if (we_e.cyc >= 0) check("mem_we_cycle", 64'(cyc), 64'(we_e.cyc));
            end
        end
        if (rd_valid === 1'b1) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got data %0h, expected none", rd_data);
            end else begin
                re_e = rq.pop_front();
                check("rd_data", rd_data, re_e.data);
                check("rd_valid_cycle", 64'(cyc), 64'(re_e.cyc));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge pclock);
            #1;
        end
    endtask

    task automatic drive_wr(input logic [18:0] a, input int exp_cyc, input bit expect_it);
        wr_we   = 1'b1;
        wr_addr = a;
        wr_data = wdata_of(a);
        if (expect_it) wq.push_back('{a, wdata_of(a), exp_cyc});
    endtask

    typedef struct {
        logic       wr_we;
        logic       rd_req;
        logic       exp_ack;
        logic [2:0] exp_level;
        logic       exp_mem_we;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int rd_n;
        int base;

        // Alternating load: grants go R, W, R, W ... and the FIFO never exceeds one entry.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0};

        // Reset state, with a pending request that must not be acked.
        reset   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 19'd5;
        step(2);
        #1;
        check("rst_rd_ack", 64'(rd_ack), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
`ifdef FB_ARB_STATS_EN
        check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
        reset  = 1'b0;
        rd_req = 1'b0;
        step();

        // Read-only: four back-to-back acks.
        for (int i = 0; i < 4; i++) begin
            rd_req  = 1'b1;
            rd_addr = 19'(100 + i);
            #1;
            check("rdonly_ack", 64'(rd_ack), 64'd1);
            rq.push_back('{init_val(19'(100 + i)), cyc + 3});
            step();
        end
        rd_req = 1'b0;
        step(5);

        // Write-only stream, each write lands two cycles after its strobe.
        for (int i = 0; i < 240; i++) begin
            drive_wr(19'(i), cyc + 2, 1'b1);
            step();
        end
        wr_we = 1'b0;
        step(4);
        check("wronly_overflow", 64'(overflow), 64'd0);
        check("wronly_level", 64'(fifo_level), 64'd0);

        // Table-driven alternating load.
        rd_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr_we) drive_wr(19'(400 + i), cyc + 2, 1'b1);
            else wr_we = 1'b0;
            rd_req  = vecs[i].rd_req;
            rd_addr = 19'(300 + rd_n);
            #1;
            check("alt_ack", 64'(rd_ack), 64'(vecs[i].exp_ack));
            check("alt_level", 64'(fifo_level), 64'(vecs[i].exp_level));
            check("alt_mem_we", 64'(mem_we), 64'(vecs[i].exp_mem_we));
            if (vecs[i].exp_ack) begin
                rq.push_back('{init_val(19'(300 + rd_n)), cyc + 3});
                rd_n++;
            end
            step();
        end
        wr_we  = 1'b0;
        rd_req = 1'b0;
        step(4);
        check("alt_overflow", 64'(overflow), 64'd0);

        // Stall for six cycles under a continuous stream: four accepted, two dropped.
        base      = cyc;
        mem_stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_wr(19'(700 + k), base + 7 + k, k < 4);
            if (k == 5) check("stall_overflow_set", 64'(overflow), 64'd1);
            step();
        end
        check("stall_level_full", 64'(fifo_level), 64'd4);
        check("stall_overflow", 64'(overflow), 64'd1);
`ifdef FB_ARB_STATS_EN
        check("stall_drop_count", 64'(drop_count), 64'd2);
`endif
        // Full FIFO with simultaneous push and pop keeps its level and drops nothing.
        mem_stall = 1'b0;
        drive_wr(19'd710, base + 11, 1'b1);
        step();
        wr_we = 1'b0;
        check("pushpop_level", 64'(fifo_level), 64'd4);
`ifdef FB_ARB_STATS_EN
        check("pushpop_drop_count", 64'(drop_count), 64'd2);
`endif
        step(6);
        check("drain_level", 64'(fifo_level), 64'd0);
        end_frame = 1'b1;
        step();
        end_frame = 1'b0;
        check("eof_overflow_clr", 64'(overflow), 64'd0);
`ifdef FB_ARB_STATS_EN
        check("eof_drop_count_clr", 64'(drop_count), 64'd0);
`endif

        // Drop coinciding with end_frame: set wins, count restarts at one.
        mem_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_wr(19'(720 + k), -1, 1'b1);
            step();
        end
        drive_wr(19'd724, -1, 1'b0);
        end_frame = 1'b1;
        step();
        end_frame = 1'b0;
        wr_we     = 1'b0;
        check("eof_drop_overflow", 64'(overflow), 64'd1);
`ifdef FB_ARB_STATS_EN
        check("eof_drop_count", 64'(drop_count), 64'd1);
`endif
        mem_stall = 1'b0;
        step(8);
        end_frame = 1'b1;
        step();
        end_frame = 1'b0;

        // Watermark: at level 3 writes win over a held read until the level drops.
        mem_stall = 1'b1;
        rd_req    = 1'b1;
        rd_addr   = 19'd310;
        for (int k = 0; k < 3; k++) begin
            drive_wr(19'(730 + k), -1, 1'b1);
            #1;
            check("stall_no_ack", 64'(rd_ack), 64'd0);
            step();
        end
        mem_stall = 1'b0;
        drive_wr(19'd733, -1, 1'b1);
        #1;
        check("hw_ack0", 64'(rd_ack), 64'd0);
        check("hw_level0", 64'(fifo_level), 64'd3);
        step();
        wr_we = 1'b0;
        #1;
        check("hw_ack1", 64'(rd_ack), 64'd0);
        check("hw_level1", 64'(fifo_level), 64'd3);
        step();
        #1;
        check("hw_ack2", 64'(rd_ack), 64'd1);
        check("hw_level2", 64'(fifo_level), 64'd2);
        rq.push_back('{init_val(19'd310), cyc + 3});
        step();
        rd_req = 1'b0;
        step(8);

        // Reset one cycle after a read ack: the read and the buffered write vanish.
        rd_req  = 1'b1;
        rd_addr = 19'd320;
        drive_wr(19'd800, -1, 1'b0);
        #1;
        check("prerst_ack", 64'(rd_ack), 64'd1);
        step();
        wr_we   = 1'b0;
        reset   = 1'b1;
        rd_addr = 19'd321;
        #1;
        check("inrst_ack", 64'(rd_ack), 64'd0);
        step();
        check("midrst_mem_we", 64'(mem_we), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr), 64'd0);
        check("midrst_mem_wdata", mem_wdata, 64'd0);
        check("midrst_rd_valid", 64'(rd_valid), 64'd0);
        check("midrst_rd_data", rd_data, 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_level", 64'(fifo_level), 64'd0);
        reset  = 1'b0;
        rd_req = 1'b0;
        step(8);

        check("writes_outstanding", 64'(wq.size()), 64'd0);
        check("reads_outstanding", 64'(rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbitrates one single-port 64-bit frame-buffer RAM between the line recorder's write stream and a readout requester. Recorder writes arrive without backpressure and are absorbed by a small write FIFO. Reads use a req/ack handshake and return data a fixed number of cycles later. The block sits between the recorder, the frame-buffer RAM and the display or readout logic, all in the `pclock` domain.

## Interface
- `WFIFO_DEPTH`, default 4: write FIFO entries (power of two, ≥2).
- `HIGH_WATER`, default 3: FIFO occupancy at or above which writes take absolute priority (1..WFIFO_DEPTH).
- `MEM_LATENCY`, default 1: RAM read latency in cycles, from registered `mem_addr` to valid `mem_rdata`.
- `pclock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `end_frame` in 1: frame boundary pulse; clears sticky overflow.
- `wr_we` in 1: recorder write strobe.
- `wr_addr` in 19: recorder word address.
- `wr_data` in 64: recorder write data.
- `rd_req` in 1: read request; held until acked; `rd_addr` stable while held.
- `rd_addr` in 19: read word address.
- `rd_ack` out 1: combinational grant; transfer occurs when `rd_req & rd_ack`.
- `rd_valid` out 1: one-cycle pulse per granted read.
- `rd_data` out 64: read data, valid with `rd_valid`.
- `mem_stall` in 1: RAM unavailable this cycle (refresh, etc.).
- `mem_addr` out 19: registered RAM address.
- `mem_we` out 1: registered RAM write enable.
- `mem_wdata` out 64: registered RAM write data.
- `mem_rdata` in 64: RAM read data.
- `overflow` out 1: sticky write-drop flag.
- `fifo_level` out clog2(WFIFO_DEPTH+1): current FIFO occupancy.

## Operation
- FIFO push occurs when `wr_we` is high and (count < WFIFO_DEPTH, or a pop happens in the same cycle). Otherwise the incoming write is dropped and `overflow` is set.
- Per-cycle grant is decided from current state. With `mem_stall` high, there is no grant.
  - Otherwise, write when the FIFO is non-empty and any of these holds: count ≥ HIGH_WATER; `rd_req` is low; the last grant was a read.
  - Otherwise, read when `rd_req` is high.
  - Otherwise, idle.
- `last_grant` register holds {WRITE, READ} and updates only on a grant. This gives round-robin below the watermark and write priority at or above it.
- Write grant: FIFO pop. Next cycle `mem_we`=1 and `mem_addr`/`mem_wdata` carry the FIFO head.
- Read grant: `rd_ack`=1. Next cycle `mem_we`=0 and `mem_addr`=`rd_addr`. A tag shift register of length MEM_LATENCY+1 tracks the in-flight read.
- Idle or stall: next cycle `mem_we`=0. `mem_addr` and `mem_wdata` hold their values.
- `rd_data` is a register loaded from `mem_rdata` when the tag exits, with `rd_valid` pulsed alongside. Reads return in grant order.
- `overflow` is set on a drop and cleared on `end_frame`. When both happen in the same cycle, set wins.

## Timing
- Uncontested write: `wr_we` in cycle c leads to `mem_we` in cycle c+2.
- Read accepted (`rd_req & rd_ack`) in cycle c: `mem_addr` in cycle c+1, `rd_valid` in cycle c+2+MEM_LATENCY (c+3 at default).
- `rd_ack` never asserts with `rd_req` low, during `reset`, or while `mem_stall` is high.
- Maximum throughput is one RAM access per cycle. With continuous writes and count ≥ HIGH_WATER, reads starve until the FIFO drains.
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `rd_valid`=0, `rd_data`=0, `rd_ack`=0.
  - `overflow`=0, `fifo_level`=0.
  - `last_grant`=READ, so a write is favoured first.
- Reset mid-operation discards FIFO contents and in-flight read tags. No `rd_valid` is produced for reads granted before reset.
- Full FIFO with push and pop in the same cycle: the push is accepted, count is unchanged, and there is no overflow.

## Configuration
- `FB_ARB_STATS_EN` defined: adds output `drop_count` (16 bits).
  - Increments on every dropped write and saturates at 16'hFFFF.
  - Clears on `reset` and on `end_frame`. When a drop and `end_frame` coincide, the result is 1.
- Not defined: the port and counter are absent. The `overflow` behaviour is identical in both builds.

## Test plan
- Write-only, 240 consecutive `wr_we` to addresses 0..239, `rd_req`=0 → 240 `mem_we` pulses in order, each 2 cycles after its input, `overflow`=0.
- Read-only, `rd_req` held across addresses 100..103, no writes → 4 acks on consecutive cycles, `rd_valid` 3 cycles after each ack, `rd_data` equal to RAM contents at 100..103.
- Alternating load: `wr_we` every other cycle plus continuous `rd_req` → grants alternate W/R, `fifo_level` ≤ 1, no drops.
- `mem_stall` high 6 cycles during a continuous write stream, DEPTH=4 → 4 accepted, then drops, `overflow`=1, `drop_count`=2 (with macro). Next `end_frame` clears both.
- Watermark: fill FIFO to 3 with `rd_req` high → writes granted until level < 3, then a read ack follows.
- Assert `reset` one cycle after a read ack → no `rd_valid`, all outputs at reset values next cycle.
